// File: rtl/count4_down.sv
// Four-bit seconds countdown timer with load, start/resume and pause controls.
// A prescaler divides CLK down to one tick per SEC1_MAX cycles while running.
module count4_down #(
  parameter int unsigned SEC1_MAX = 50000000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       LOAD,
  input  logic [3:0] LOAD_VAL,
  input  logic       START,
  input  logic       STOP,
  output logic [3:0] COUNT,
  output logic       BUSY,
  output logic       DONE
);

  localparam logic [25:0] PrescLast = 26'(SEC1_MAX - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [25:0] presc_q, presc_d;
  logic [3:0]  count_q, count_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        tick;

  assign tick = (state_q == StRun) && (presc_q == PrescLast);

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    count_d = count_q;
    done_d  = 1'b0;

    if (LOAD) begin
      count_d = LOAD_VAL;
      presc_d = '0;
      state_d = StIdle;
    end else if (STOP) begin
      // STOP masks START even when STOP itself has no effect.
      if (state_q == StRun) begin
        state_d = StPause;
      end
    end else if (START && (state_q != StRun)) begin
      if (state_q == StPause) begin
        state_d = StRun;
      end else if (count_q != 4'd0) begin
        state_d = StRun;
        presc_d = '0;
      end
    end else if (tick) begin
      presc_d = '0;
      if (count_q > 4'd1) begin
        count_d = count_q - 4'd1;
      end else begin
        count_d = 4'd0;
        state_d = StIdle;
        done_d  = 1'b1;
      end
    end else if (state_q == StRun) begin
      presc_d = presc_q + 26'd1;
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= StIdle;
      presc_q <= '0;
      count_q <= 4'h0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign COUNT = count_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;

endmodule

// File: tb/tb_count4_down.sv
// Directed bench for count4_down with a four-cycle second.
module tb_count4_down;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       LOAD = 1'b0;
  logic [3:0] LOAD_VAL = 4'h0;
  logic       START = 1'b0;
  logic       STOP = 1'b0;
  logic [3:0] COUNT;
  logic       BUSY;
  logic       DONE;

  int passed = 0;
  int total = 0;

  count4_down #(.SEC1_MAX(4)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .LOAD(LOAD),
    .LOAD_VAL(LOAD_VAL),
    .START(START),
    .STOP(STOP),
    .COUNT(COUNT),
    .BUSY(BUSY),
    .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_load(input logic [3:0] v);
    LOAD = 1'b1;
    LOAD_VAL = v;
    step();
    LOAD = 1'b0;
  endtask

  task automatic do_start();
    START = 1'b1;
    step();
    START = 1'b0;
  endtask

  task automatic test_reset();
    step();
    step();
    #2 RESET = 1'b1;
    total++;
    if ({COUNT, BUSY, DONE} !== 6'b0000_0_0)
      $display("FAIL reset_state: got count=%0d busy=%b done=%b, want 0/0/0", COUNT, BUSY, DONE);
    else passed++;
    step();
    START = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      total++;
      if ({COUNT, BUSY, DONE} !== 6'b0000_0_0)
        $display("FAIL start_at_zero[%0d]: got count=%0d busy=%b done=%b, want 0/0/0",
                 i, COUNT, BUSY, DONE);
      else passed++;
    end
    START = 1'b0;
  endtask

  task automatic test_countdown();
    logic [3:0] exp_count;
    do_load(4'd3);
    do_start();
    total++;
    if (COUNT !== 4'd3 || BUSY !== 1'b1 || DONE !== 1'b0)
      $display("FAIL cd_start: got count=%0d busy=%b done=%b, want 3/1/0", COUNT, BUSY, DONE);
    else passed++;
    for (int k = 1; k <= 13; k++) begin
      step();
      exp_count = (k >= 12) ? 4'd0 : 4'(3 - k / 4);
      total++;
      if (COUNT !== exp_count || BUSY !== (k < 12) || DONE !== (k == 12))
        $display("FAIL cd_edge%0d: got count=%0d busy=%b done=%b, want %0d/%b/%b",
                 k, COUNT, BUSY, DONE, exp_count, (k < 12), (k == 12));
      else passed++;
    end
  endtask

  task automatic test_pause_resume();
    do_load(4'd5);
    do_start();
    step();
    step();
    step();
    STOP = 1'b1;
    step();
    STOP = 1'b0;
    for (int i = 0; i < 6; i++) begin
      total++;
      if (COUNT !== 4'd5 || BUSY !== 1'b1 || DONE !== 1'b0)
        $display("FAIL pause_hold[%0d]: got count=%0d busy=%b done=%b, want 5/1/0",
                 i, COUNT, BUSY, DONE);
      else passed++;
      step();
    end
    do_start();
    total++;
    if (COUNT !== 4'd5 || BUSY !== 1'b1)
      $display("FAIL resume_enter: got count=%0d busy=%b, want 5/1", COUNT, BUSY);
    else passed++;
    step();
    total++;
    if (COUNT !== 4'd4 || BUSY !== 1'b1)
      $display("FAIL resume_tick: got count=%0d busy=%b, want 4/1", COUNT, BUSY);
    else passed++;
    // START while running must not restart the prescaler.
    START = 1'b1;
    for (int i = 0; i < 4; i++) step();
    START = 1'b0;
    total++;
    if (COUNT !== 4'd3)
      $display("FAIL start_in_run: got count=%0d, want 3", COUNT);
    else passed++;
  endtask

  task automatic test_load_during_run();
    do_load(4'd7);
    do_start();
    for (int i = 0; i < 4; i++) step();
    total++;
    if (COUNT !== 4'd6)
      $display("FAIL reach_six: got count=%0d, want 6", COUNT);
    else passed++;
    do_load(4'd9);
    for (int i = 0; i < 6; i++) begin
      total++;
      if (COUNT !== 4'd9 || BUSY !== 1'b0 || DONE !== 1'b0)
        $display("FAIL load_in_run[%0d]: got count=%0d busy=%b done=%b, want 9/0/0",
                 i, COUNT, BUSY, DONE);
      else passed++;
      step();
    end
  endtask

  task automatic test_start_stop_together();
    START = 1'b1;
    STOP = 1'b1;
    step();
    step();
    START = 1'b0;
    STOP = 1'b0;
    for (int i = 0; i < 6; i++) begin
      total++;
      if (COUNT !== 4'd9 || BUSY !== 1'b0 || DONE !== 1'b0)
        $display("FAIL start_stop_idle[%0d]: got count=%0d busy=%b done=%b, want 9/0/0",
                 i, COUNT, BUSY, DONE);
      else passed++;
      step();
    end
  endtask

  task automatic test_async_reset();
    do_load(4'd3);
    do_start();
    for (int i = 0; i < 4; i++) step();
    total++;
    if (COUNT !== 4'd2 || BUSY !== 1'b1)
      $display("FAIL pre_reset: got count=%0d busy=%b, want 2/1", COUNT, BUSY);
    else passed++;
    #1 RESET = 1'b0;
    #1;
    total++;
    if (COUNT !== 4'd0 || BUSY !== 1'b0 || DONE !== 1'b0)
      $display("FAIL async_reset: got count=%0d busy=%b done=%b, want 0/0/0", COUNT, BUSY, DONE);
    else passed++;
    #1 RESET = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      total++;
      if (COUNT !== 4'd0 || BUSY !== 1'b0 || DONE !== 1'b0)
        $display("FAIL post_reset[%0d]: got count=%0d busy=%b done=%b, want 0/0/0",
                 i, COUNT, BUSY, DONE);
      else passed++;
    end
  endtask

  task automatic test_full_15();
    int         dones;
    logic [3:0] exp_count;
    dones = 0;
    do_load(4'd15);
    do_start();
    for (int k = 1; k <= 70; k++) begin
      step();
      exp_count = (k >= 60) ? 4'd0 : 4'(15 - k / 4);
      if (DONE === 1'b1) dones++;
      total++;
      if (COUNT !== exp_count || BUSY !== (k < 60))
        $display("FAIL full15_edge%0d: got count=%0d busy=%b, want %0d/%b",
                 k, COUNT, BUSY, exp_count, (k < 60));
      else passed++;
    end
    total++;
    if (dones !== 1)
      $display("FAIL full15_done_pulses: got %0d, want 1", dones);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_pause_resume();
    test_load_during_run();
    test_start_stop_together();
    test_async_reset();
    test_full_15();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/count4_down.md
COUNT4_DOWN -- requirements
Module: count4_down

Interface
REQ-001 SHALL have parameter SEC1_MAX, default 50000000, meaning clock cycles per 1-second tick (50 MHz clock).
REQ-002 SHALL have port CLK  input  1  the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port RESET  input  1  asynchronous, active-low reset (0 = reset).
REQ-004 SHALL have port LOAD  input  1  synchronous load strobe, sampled on the CLK rising edge.
REQ-005 SHALL have port LOAD_VAL  input  4  countdown start value, captured when LOAD=1.
REQ-006 SHALL have port START  input  1  level-sampled start/resume request.
REQ-007 SHALL have port STOP  input  1  level-sampled pause request.
REQ-008 SHALL have port COUNT  output  4  registered remaining seconds.
REQ-009 SHALL have port BUSY  output  1  registered; 1 while the state is RUN or PAUSE.
REQ-010 SHALL have port DONE  output  1  registered one-cycle pulse when the countdown reaches 0.

Function
REQ-011 SHALL implement states IDLE, RUN and PAUSE, plus a 26-bit prescaler.
REQ-012 The internal tick SHALL be asserted only when state=RUN and prescaler=SEC1_MAX-1.
REQ-013 In RUN, the prescaler SHALL increment by 1 per cycle, and SHALL wrap to 0 on the tick cycle.
REQ-014 In PAUSE, the prescaler SHALL hold its value.
REQ-015 In IDLE, the prescaler SHALL be 0.
REQ-016 Per-cycle input priority SHALL be LOAD > STOP > START > tick.
REQ-017 LOAD=1 in any state SHALL set COUNT<=LOAD_VAL, clear the prescaler to 0 and set the state to IDLE; a tick in that same cycle SHALL be discarded.
REQ-018 START in IDLE with COUNT!=0 SHALL enter RUN with the prescaler at 0.
REQ-019 START in IDLE with COUNT=0 SHALL be ignored: the state stays IDLE and DONE stays 0.
REQ-020 START in PAUSE SHALL enter RUN with the prescaler value retained (resume).
REQ-021 START in RUN SHALL be ignored.
REQ-022 STOP in RUN SHALL enter PAUSE; a tick in the same cycle SHALL be discarded, with COUNT and prescaler holding.
REQ-023 STOP in IDLE or PAUSE SHALL be ignored.
REQ-024 START and STOP asserted together SHALL be treated as STOP.
REQ-025 On a tick with COUNT>1, COUNT SHALL decrement by 1 and the state SHALL remain RUN.
REQ-026 On a tick with COUNT=1, the same edge SHALL set COUNT to 0, set the state to IDLE, drive BUSY to 0 and drive DONE to 1.
REQ-027 DONE SHALL be 0 in the following cycle unless re-triggered.
REQ-028 COUNT SHALL never wrap from 0 to 15.
REQ-029 Latency: with START sampled at edge N from IDLE, the first decrement SHALL occur at edge N+SEC1_MAX, and each subsequent decrement SHALL follow at SEC1_MAX-cycle intervals.
REQ-030 BUSY and DONE SHALL be driven directly from registers (no combinational path from inputs).

Reset
REQ-031 RESET=0 SHALL asynchronously force state=IDLE, prescaler=0, COUNT=4'h0, BUSY=0 and DONE=0, regardless of CLK.
REQ-032 RESET asserted mid-RUN or mid-PAUSE SHALL abort the countdown without a DONE pulse.
REQ-033 After RESET deasserts, the block SHALL take no action until LOAD or START is sampled.

Verification (SEC1_MAX=4)
REQ-034 Reset release -> COUNT=0, BUSY=0, DONE=0; START alone -> no state change, no DONE.
REQ-035 LOAD with LOAD_VAL=3, then START at edge N -> COUNT=2 at N+4, 1 at N+8, 0 at N+12; DONE=1 only in the cycle after N+12; BUSY=1 from N to N+12.
REQ-036 LOAD 5, START, STOP at the cycle the prescaler=3 -> COUNT stays 5, state PAUSE, BUSY=1; START -> COUNT=4 one edge after entering RUN.
REQ-037 LOAD 9 during RUN at COUNT=6 -> COUNT=9, BUSY=0, no DONE; START and STOP together from IDLE -> stays IDLE.
REQ-038 RESET pulsed low between edges during RUN at COUNT=2 -> immediate COUNT=0, BUSY=0, no DONE pulse afterward.
REQ-039 LOAD_VAL=15 full countdown -> 15 decrements, COUNT ends at 0, exactly one DONE pulse, no wrap to 15.
